// File: rtl/vga_framebuffer_reader_pkg.sv
// Shared VGA timing constants, RGB332 field positions and swap FSM encoding
// for the framebuffer reader.
package vga_framebuffer_reader_pkg;

  localparam int VgaWidth     = 640;
  localparam int VgaHeight    = 480;
  localparam int HFrontPorch  = 16;
  localparam int HSyncWidth   = 96;
  localparam int HBackPorch   = 48;
  localparam int VFrontPorch  = 10;
  localparam int VSyncWidth   = 2;
  localparam int VBackPorch   = 33;
  localparam int HTotal       = VgaWidth + HFrontPorch + HSyncWidth + HBackPorch;
  localparam int VTotal       = VgaHeight + VFrontPorch + VSyncWidth + VBackPorch;

  localparam int RedMsb   = 7;
  localparam int RedLsb   = 5;
  localparam int GreenMsb = 4;
  localparam int GreenLsb = 2;
  localparam int BlueMsb  = 1;
  localparam int BlueLsb  = 0;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/vga_framebuffer_reader_if.sv
// Bundle between the VGA timing source / framebuffer memory and the reader.
interface vga_framebuffer_reader_if #(
  parameter int CoordWidth      = 10,
  parameter int MemAddressWidth = 16
);
  logic [CoordWidth-1:0]      line;
  logic [CoordWidth-1:0]      column;
  logic                       horizontalSync;
  logic                       verticalSync;
  logic [MemAddressWidth-1:0] memAddress;
  logic [7:0]                 memData;
  logic                       swapRequest;
  logic                       swapAck;
  logic [2:0]                 red;
  logic [2:0]                 green;
  logic [1:0]                 blue;
  logic                       hSyncOut;
  logic                       vSyncOut;
  logic [15:0]                frameCount;

  modport master (
    output line, column, horizontalSync, verticalSync, memData, swapRequest,
    input  memAddress, swapAck, red, green, blue, hSyncOut, vSyncOut, frameCount
  );

  modport slave (
    input  line, column, horizontalSync, verticalSync, memData, swapRequest,
    output memAddress, swapAck, red, green, blue, hSyncOut, vSyncOut, frameCount
  );
endinterface

// File: rtl/vga_signal_delay.sv
// Fixed-depth shift register used to align syncs/visible with the colour path.
module vga_signal_delay #(
  parameter int Width = 1,
  parameter int Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Scaled double-buffered framebuffer reader: turns VGA coordinates into
// RGB332 fetches and presents colour/syncs two clocks after the coordinates.
module vga_framebuffer_reader
  import vga_framebuffer_reader_pkg::*;
#(
  parameter int Width           = VgaWidth,
  parameter int Height          = VgaHeight,
  parameter int ScaleShift      = 2,
  parameter int CoordWidth      = 10,
  parameter int MemAddressWidth = $clog2(2 * (Width >> ScaleShift) * (Height >> ScaleShift))
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_framebuffer_reader_if.slave  bus
);

  // state         | meaning
  // SWAP_IDLE     | displaying current buffer, no flip requested
  // SWAP_PENDING  | flip requested, waits for the next frame start

  localparam int OffsetWidth = MemAddressWidth - 1;
  localparam logic [OffsetWidth-1:0] RowStride = OffsetWidth'(Width >> ScaleShift);

  swap_state_e             state_q, state_d;
  logic                    buf_sel_q, buf_sel_d;
  logic                    swap_ack_q, swap_ack_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic [CoordWidth-1:0]   line_q;
  logic [OffsetWidth-1:0]  row_base_q, row_base_d;
  logic [OffsetWidth-1:0]  offset, offset_vis;
  logic [7:0]              pix_q;
  logic                    visible, frame_start, row_wrap, vis_dly;

  assign visible     = (bus.column < CoordWidth'(Width)) && (bus.line < CoordWidth'(Height));
  assign frame_start = (bus.line == '0) && (bus.column == '0);
  // A new framebuffer row starts every 2**ScaleShift visible lines; blanking lines never advance it.
  assign row_wrap    = (bus.line != line_q) && (bus.line[ScaleShift-1:0] == '0)
                       && (bus.line < CoordWidth'(Height));

  always_comb begin
    row_base_d = row_base_q;
    if (bus.line == '0)  row_base_d = '0;
    else if (row_wrap)   row_base_d = row_base_q + RowStride;
  end

  assign offset         = row_base_d + OffsetWidth'(bus.column >> ScaleShift);
  assign offset_vis     = visible ? offset : '0;
  // Use the post-decision buffer bit so the first pixel of a frame already reads the new buffer.
  assign bus.memAddress = {buf_sel_d, offset_vis};

  always_comb begin
    state_d       = state_q;
    buf_sel_d     = buf_sel_q;
    swap_ack_d    = 1'b0;
    frame_count_d = frame_start ? frame_count_q + 16'd1 : frame_count_q;
    case (state_q)
      SWAP_IDLE: begin
        if (bus.swapRequest) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (frame_start) begin
          state_d    = SWAP_IDLE;
          buf_sel_d  = ~buf_sel_q;
          swap_ack_d = 1'b1;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SWAP_IDLE;
      buf_sel_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_count_q <= '0;
      line_q        <= '0;
      row_base_q    <= '0;
      pix_q         <= '0;
    end else begin
      state_q       <= state_d;
      buf_sel_q     <= buf_sel_d;
      swap_ack_q    <= swap_ack_d;
      frame_count_q <= frame_count_d;
      line_q        <= bus.line;
      row_base_q    <= row_base_d;
      pix_q         <= bus.memData;
    end
  end

  vga_signal_delay #(.Width(3), .Depth(2)) u_sync_delay (
    .clk    (clk),
    .rst    (rst),
    .data_i ({visible, bus.horizontalSync, bus.verticalSync}),
    .data_o ({vis_dly, bus.hSyncOut, bus.vSyncOut})
  );

  assign bus.red        = vis_dly ? pix_q[RedMsb:RedLsb]     : 3'd0;
  assign bus.green      = vis_dly ? pix_q[GreenMsb:GreenLsb] : 3'd0;
  assign bus.blue       = vis_dly ? pix_q[BlueMsb:BlueLsb]   : 2'd0;
  assign bus.swapAck    = swap_ack_q;
  assign bus.frameCount = frame_count_q;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Directed bench for vga_framebuffer_reader: addressing, 2-clock colour/sync
// alignment, blanking, buffer swap handshake, frame counter and reset.
module tb_vga_framebuffer_reader;
  import vga_framebuffer_reader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  vga_framebuffer_reader_if #(.CoordWidth(10), .MemAddressWidth(16)) bus ();

  vga_framebuffer_reader #(
    .Width(640), .Height(480), .ScaleShift(2), .CoordWidth(10), .MemAddressWidth(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rgb();
    return {24'd0, bus.red, bus.green, bus.blue};
  endfunction

  function automatic logic [31:0] syncs();
    return {30'd0, bus.hSyncOut, bus.vSyncOut};
  endfunction

  function automatic logic [31:0] addr();
    return {16'd0, bus.memAddress};
  endfunction

  function automatic logic [31:0] bufbit();
    return {31'd0, bus.memAddress[15]};
  endfunction

  // One clock: drive new coordinates/syncs/memData just after the rising edge.
  task automatic step(input int l, input int c, input logic hs, input logic vs,
                      input logic [7:0] md);
    @(posedge clk);
    #1;
    bus.line           = 10'(l);
    bus.column         = 10'(c);
    bus.horizontalSync = hs;
    bus.verticalSync   = vs;
    bus.memData        = md;
    #1;
  endtask

  initial begin
    int cols [3];
    cols[0] = 0;
    cols[1] = VgaWidth - 1;
    cols[2] = HTotal - 1;

    bus.line = 10'd500; bus.column = 10'd700;
    bus.horizontalSync = 1'b0; bus.verticalSync = 1'b0;
    bus.memData = 8'h00; bus.swapRequest = 1'b0;

    #12;
    chk("rst_rgb",   rgb(), 32'h0);
    chk("rst_sync",  syncs(), 32'h0);
    chk("rst_ack",   32'(bus.swapAck), 32'h0);
    chk("rst_count", 32'(bus.frameCount), 32'h0);
    chk("rst_addr",  addr(), 32'h0);
    @(negedge clk) rst = 1'b0;

    // column scaling and 2-clock colour/sync latency
    step(0, 0, 1, 1, 8'h00); chk("a_addr0", addr(), 32'd0);
    step(0, 1, 0, 1, 8'hE0); chk("a_addr1", addr(), 32'd0);
    step(0, 2, 0, 0, 8'h1C); chk("a_addr2", addr(), 32'd0);
    chk("a_rgb0", rgb(), 32'hE0); chk("a_sync0", syncs(), 32'd3);
    step(0, 3, 1, 0, 8'h03); chk("a_addr3", addr(), 32'd0);
    chk("a_rgb1", rgb(), 32'h1C); chk("a_sync1", syncs(), 32'd1);
    step(0, 4, 0, 0, 8'h00); chk("a_addr4", addr(), 32'd1);
    chk("a_rgb2", rgb(), 32'h03); chk("a_sync2", syncs(), 32'd0);
    step(0, 5, 0, 0, 8'h00);
    chk("a_rgb3", rgb(), 32'h00); chk("a_sync3", syncs(), 32'd2);

    // second framebuffer row
    step(4, 8, 0, 0, 8'h00);  chk("b_addr", addr(), 32'd162);
    step(4, 9, 0, 0, 8'hE0);
    step(4, 10, 0, 0, 8'h00);
    chk("b_red", 32'(bus.red), 32'd7);
    chk("b_gb", {27'd0, bus.green, bus.blue}, 32'd0);

    // horizontal blanking
    step(4, 700, 1, 0, 8'h00); chk("c_addr", addr(), 32'd0);
    step(4, 701, 0, 1, 8'hFF);
    step(4, 702, 0, 0, 8'hFF);
    chk("c_rgb0", rgb(), 32'd0); chk("c_sync0", syncs(), 32'd2);
    step(4, 703, 0, 0, 8'hFF);
    chk("c_rgb1", rgb(), 32'd0); chk("c_sync1", syncs(), 32'd1);

    // swap requested mid-frame, served at the frame start
    bus.swapRequest = 1'b1;
    step(4, 20, 0, 0, 8'h00);   chk("d_buf_mid", bufbit(), 32'd0);
    step(100, 50, 0, 0, 8'h00); chk("d_buf_mid2", bufbit(), 32'd0);
    chk("d_ack_mid", 32'(bus.swapAck), 32'd0);
    step(0, 0, 0, 0, 8'h00);    chk("d_buf_flip", bufbit(), 32'd1);
    chk("d_ack_pre", 32'(bus.swapAck), 32'd0);
    step(0, 1, 0, 0, 8'h00);    chk("d_ack", 32'(bus.swapAck), 32'd1);
    chk("d_buf_hold", bufbit(), 32'd1);
    bus.swapRequest = 1'b0;
    step(0, 2, 0, 0, 8'h00);    chk("d_ack_end", 32'(bus.swapAck), 32'd0);

    // reset while a swap is pending
    bus.swapRequest = 1'b1;
    step(10, 10, 1, 1, 8'h00);
    step(10, 11, 1, 1, 8'hE0);
    bus.swapRequest = 1'b0;
    step(10, 12, 1, 1, 8'hE0);
    chk("e_red_pre", 32'(bus.red), 32'd7);
    chk("e_buf_pre", bufbit(), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("e_rgb", rgb(), 32'd0);
    chk("e_sync", syncs(), 32'd0);
    chk("e_count", 32'(bus.frameCount), 32'd0);
    chk("e_buf", bufbit(), 32'd0);
    chk("e_ack", 32'(bus.swapAck), 32'd0);
    #2 rst = 1'b0;
    step(10, 13, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);  chk("e_buf_bnd", bufbit(), 32'd0);
    step(0, 1, 0, 0, 8'h00);  chk("e_no_ack", 32'(bus.swapAck), 32'd0);
    step(0, 2, 0, 0, 8'h00);  chk("e_no_ack2", 32'(bus.swapAck), 32'd0);

    // request first seen on the boundary cycle waits for the next boundary
    step(0, 0, 0, 0, 8'h00);
    bus.swapRequest = 1'b1;
    chk("g_buf_same", bufbit(), 32'd0);
    step(0, 1, 0, 0, 8'h00);  chk("g_no_ack", 32'(bus.swapAck), 32'd0);
    step(0, 2, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);  chk("g_buf_flip", bufbit(), 32'd1);
    step(0, 1, 0, 0, 8'h00);  chk("g_ack", 32'(bus.swapAck), 32'd1);
    bus.swapRequest = 1'b0;

    // frame counter over full-height frames, then wrap
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < VTotal; l++) begin
        for (int k = 0; k < 3; k++) begin
          step(l, cols[k], 1'b0, 1'b0, 8'h00);
          if (f == 0 && l == VgaHeight - 1 && k == 1) chk("f_addr_last", addr(), 32'd19199);
        end
      end
    end
    chk("f_count3", 32'(bus.frameCount), 32'd3);
    for (int i = 0; i < 65532; i++) step(0, 0, 1'b0, 1'b0, 8'h00);
    step(0, 1, 1'b0, 1'b0, 8'h00);
    chk("f_count_max", 32'(bus.frameCount), 32'hFFFF);
    step(0, 0, 1'b0, 1'b0, 8'h00);
    step(0, 1, 1'b0, 1'b0, 8'h00);
    chk("f_count_wrap", 32'(bus.frameCount), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
